// File: rtl/phys_reg_free_list_ckpt.sv
// phys_reg_free_list_ckpt: circular free list of physical register tags with head-pointer checkpoints
module phys_reg_free_list_ckpt #(
  parameter int NUM_PHYS_REGS = 64,
  parameter int NUM_ARCH_REGS = 32,
  parameter int CHECKPOINT_COLUMNS = 4,
  localparam int TAG_W = $clog2(NUM_PHYS_REGS),
  localparam int DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS,
  localparam int COL_W = $clog2(CHECKPOINT_COLUMNS),
  localparam int IDX_W = $clog2(DEPTH),
  localparam int PTR_W = IDX_W + 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             dequeue_valid,
  output logic             dequeue_ready,
  output logic [TAG_W-1:0] dequeue_tag,
  input  logic             enqueue_valid,
  input  logic [TAG_W-1:0] enqueue_tag,
  output logic             enqueue_ready,
  input  logic             save_valid,
  input  logic [COL_W-1:0] save_column,
  input  logic             restore_valid,
  input  logic [COL_W-1:0] restore_column,
  output logic [CNT_W-1:0] count,
  output logic             overflow_error
);
  logic [TAG_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] ckpt [CHECKPOINT_COLUMNS];
  logic [PTR_W-1:0] head, tail, used, head_deq;
  logic             empty, full, deq, enq, overflow;
  assign used = tail - head;
  assign empty = used == '0;
  assign full = used == PTR_W'(DEPTH);
  assign deq = dequeue_valid && !empty;
  assign enq = enqueue_valid && !full;
  // checkpoints capture the head as it will stand after this cycle's dequeue
  assign head_deq = head + PTR_W'(deq);
  assign dequeue_ready = !empty;
  assign enqueue_ready = !full;
  assign dequeue_tag = mem[head[IDX_W-1:0]];
  assign count = CNT_W'(used);
  assign overflow_error = overflow;
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= TAG_W'(NUM_ARCH_REGS + i);
      for (int i = 0; i < CHECKPOINT_COLUMNS; i++) ckpt[i] <= '0;
      head <= '0;
      tail <= PTR_W'(DEPTH);
      overflow <= 1'b0;
    end else begin
      head <= restore_valid ? ckpt[restore_column] : head_deq;
      if (save_valid && !restore_valid) ckpt[save_column] <= head_deq;
      if (enq) begin
        mem[tail[IDX_W-1:0]] <= enqueue_tag;
        tail <= tail + PTR_W'(1);
      end
      if (enqueue_valid && full) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_phys_reg_free_list_ckpt.sv
// tb_phys_reg_free_list_ckpt: directed and random checks against an unbounded-counter free list model
module tb_phys_reg_free_list_ckpt;
  localparam int DEPTH = 32;
  logic       CLK = 0, RST = 0;
  logic       dequeue_valid = 0, dequeue_ready, enqueue_valid = 0, enqueue_ready;
  logic       save_valid = 0, restore_valid = 0, overflow_error;
  logic [5:0] dequeue_tag, enqueue_tag = 0;
  logic [1:0] save_column = 0, restore_column = 0;
  logic [5:0] count;
  int errors = 0, checks = 0;
  int m_head, m_tail, m_ovf;
  int m_ck [4];
  int m_mem [DEPTH];

  phys_reg_free_list_ckpt dut (
    .CLK(CLK), .RST(RST),
    .dequeue_valid(dequeue_valid), .dequeue_ready(dequeue_ready), .dequeue_tag(dequeue_tag),
    .enqueue_valid(enqueue_valid), .enqueue_tag(enqueue_tag), .enqueue_ready(enqueue_ready),
    .save_valid(save_valid), .save_column(save_column),
    .restore_valid(restore_valid), .restore_column(restore_column),
    .count(count), .overflow_error(overflow_error)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".tag"}, int'(dequeue_tag), m_mem[m_head % DEPTH]);
    chk({tag, ".dq_rdy"}, int'(dequeue_ready), int'(m_tail != m_head));
    chk({tag, ".eq_rdy"}, int'(enqueue_ready), int'(m_tail - m_head != DEPTH));
    chk({tag, ".count"}, int'(count), m_tail - m_head);
    chk({tag, ".ovf"}, int'(overflow_error), m_ovf);
  endtask

  task automatic cyc(input string tag, input bit rst, input bit dv, input bit ev, input int et,
                     input bit sv, input int sc, input bit rv, input int rc);
    int cnt, hd;
    bit d, e;
    RST = rst; dequeue_valid = dv; enqueue_valid = ev; enqueue_tag = 6'(et);
    save_valid = sv; save_column = 2'(sc); restore_valid = rv; restore_column = 2'(rc);
    @(posedge CLK);
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 32 + i;
      foreach (m_ck[i]) m_ck[i] = 0;
      m_head = 0; m_tail = DEPTH; m_ovf = 0;
    end else begin
      cnt = m_tail - m_head;
      d = dv && cnt != 0;
      e = ev && cnt != DEPTH;
      hd = m_head + int'(d);
      if (ev && !e) m_ovf = 1;
      if (e) begin
        m_mem[m_tail % DEPTH] = et;
        m_tail++;
      end
      if (rv) m_head = m_ck[rc];
      else begin
        if (sv) m_ck[sc] = hd;
        m_head = hd;
      end
    end
    #1;
    RST = 0; dequeue_valid = 0; enqueue_valid = 0; save_valid = 0; restore_valid = 0;
    chk_all(tag);
  endtask

  initial begin
    cyc("reset", 1, 0, 0, 0, 0, 0, 0, 0);
    chk("reset.tag32", int'(dequeue_tag), 32);
    chk("reset.count32", int'(count), 32);
    for (int i = 0; i < 32; i++) begin
      chk("drain.order", int'(dequeue_tag), 32 + i);
      cyc("drain", 0, 1, 0, 0, 0, 0, 0, 0);
    end
    chk("empty.count", int'(count), 0);
    chk("empty.ready", int'(dequeue_ready), 0);
    cyc("deq_empty", 0, 1, 0, 0, 0, 0, 0, 0);
    chk("deq_empty.count", int'(count), 0);
    cyc("enq5", 0, 0, 1, 5, 0, 0, 0, 0);
    cyc("enq9", 0, 0, 1, 9, 0, 0, 0, 0);
    chk("enq.count2", int'(count), 2);
    chk("deq.first5", int'(dequeue_tag), 5);
    cyc("deq5", 0, 1, 0, 0, 0, 0, 0, 0);
    chk("deq.then9", int'(dequeue_tag), 9);
    cyc("deq9", 0, 1, 0, 0, 0, 0, 0, 0);
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 32; i++) cyc("fill", 0, 0, 1, (i * 7 + r) % 64, 0, 0, 0, 0);
      chk("fill.full", int'(enqueue_ready), 0);
      for (int i = 0; i < 32; i++) begin
        chk("wrap.order", int'(dequeue_tag), (i * 7 + r) % 64);
        cyc("wrapdrain", 0, 1, 0, 0, 0, 0, 0, 0);
      end
    end
    cyc("reset2", 1, 0, 0, 0, 0, 0, 0, 0);
    cyc("d32", 0, 1, 0, 0, 0, 0, 0, 0);
    cyc("d33", 0, 1, 0, 0, 0, 0, 0, 0);
    cyc("d34save", 0, 1, 0, 0, 1, 1, 0, 0);
    cyc("d35", 0, 1, 0, 0, 0, 0, 0, 0);
    cyc("d36", 0, 1, 0, 0, 0, 0, 0, 0);
    cyc("restore1", 0, 0, 0, 0, 0, 0, 1, 1);
    chk("restore.tag35", int'(dequeue_tag), 35);
    chk("restore.count29", int'(count), 29);
    cyc("reset3", 1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc("pre", 0, 1, 0, 0, 0, 0, 0, 0);
    cyc("save2", 0, 0, 0, 0, 1, 2, 0, 0);
    cyc("post1", 0, 1, 0, 0, 0, 0, 0, 0);
    cyc("post2", 0, 1, 0, 0, 0, 0, 0, 0);
    cyc("rde", 0, 1, 1, 7, 1, 2, 1, 2);
    chk("rde.tag35", int'(dequeue_tag), 35);
    chk("rde.count30", int'(count), 30);
    for (int i = 0; i < 29; i++) cyc("rdedrain", 0, 1, 0, 0, 0, 0, 0, 0);
    chk("rde.tag7", int'(dequeue_tag), 7);
    cyc("reset4", 1, 0, 0, 0, 0, 0, 0, 0);
    cyc("ovf", 0, 0, 1, 3, 0, 0, 0, 0);
    chk("ovf.count32", int'(count), 32);
    chk("ovf.set", int'(overflow_error), 1);
    for (int i = 0; i < 3; i++) cyc("ovfhold", 0, 1, 0, 0, 0, 0, 0, 0);
    chk("ovf.held", int'(overflow_error), 1);
    cyc("ovfclr", 1, 0, 0, 0, 0, 0, 0, 0);
    chk("ovf.clear", int'(overflow_error), 0);
    for (int i = 0; i < 600; i++) begin
      int rc;
      bit rv;
      rc = int'($urandom_range(0, 3));
      rv = ($urandom_range(0, 9) == 0) && (m_tail - m_ck[rc] <= DEPTH);
      cyc("rand", 0, $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, int'($urandom_range(0, 63)),
          $urandom_range(0, 3) == 0, int'($urandom_range(0, 3)), rv, rc);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
